// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a FIFO read port into a 2-entry in-order
// output buffer and presents them on a valid/ready downstream interface.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          1 = fetch words from the FIFO, 0 = stop fetching
//   clr_err         synchronous clear of underflow_err
//   fifo_rd_en      read strobe to the FIFO
//   fifo_data_out   FIFO read data, valid the cycle after an accepted read
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   m_valid/m_data  downstream word (buffer head)
//   m_ready         downstream accept
//   rd_count        count of completed downstream transfers (wraps)
//   underflow_err   sticky underflow indication
//   busy            state != IDLE or a word is still buffered
//
// state | meaning
// IDLE  | not fetching, waiting for enable
// RUN   | issuing FIFO reads while buffer space allows
// STOP  | enable dropped, waiting for the in-flight word to land
module fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clr_err,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            occ;
  logic                  inf;
  logic                  pop;
  logic [2:0]            committed;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_head;
  assign pop     = m_valid & m_ready;
  assign busy    = (state != IDLE) | m_valid;

  // Slots that will be occupied after this edge, counting the in-flight word.
  assign committed = {1'b0, occ} + {2'b00, inf} - {2'b00, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN:  if (!enable) state_nxt = STOP;
      STOP: begin
        if (enable)    state_nxt = RUN;
        else if (!inf) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A read issued now lands next cycle, so it needs a free slot after this
    // edge; this is what makes a capture into a full buffer impossible.
    if (state == RUN && !fifo_empty && committed < 3'd2) fifo_rd_en = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inf      <= 1'b0;
      buf_head <= '0;
      buf_tail <= '0;
      rd_count <= '0;
    end else begin
      inf <= fifo_rd_en;
      occ <= occ + {1'b0, inf} - {1'b0, pop};
      if (pop) buf_head <= buf_tail;
      // Capture goes to the slot that is the tail after any pop; a capture
      // into an otherwise-emptied head overrides the shift above.
      if (inf) begin
        if (occ == 2'd0 || (occ == 2'd1 && pop)) buf_head <= fifo_data_out;
        else                                      buf_tail <= fifo_data_out;
      end
      if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              underflow_err <= 1'b0;
    else if (fifo_underflow) underflow_err <= 1'b1;
    else if (clr_err)        underflow_err <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, enable, clr_err, fifo_rd_en, fifo_empty, fifo_underflow;
  logic          m_valid, m_ready, underflow_err, busy;
  logic [DW-1:0] fifo_data_out, m_data;
  logic [CW-1:0] rd_count;

  int vectors = 0;
  int miscompares = 0;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .rd_count(rd_count), .underflow_err(underflow_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on fifo_data_out the cycle after an accepted read.
  logic [DW-1:0] mem [64];
  logic [5:0]    rd_ptr = 6'd0;
  logic [5:0]    wr_ptr = 6'd0;
  logic          force_empty = 1'b0;
  int            nreads = 0;
  int            bad_rd = 0;
  logic [DW-1:0] log_q [$];

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      nreads <= nreads + 1;
      if (fifo_empty) bad_rd <= bad_rd + 1;
      else begin
        fifo_data_out <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 6'd1;
      end
    end
  end

  always @(negedge clk)
    if (rst_n && m_valid && m_ready) log_q.push_back(m_data);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; clr_err = 1'b0;
    fifo_underflow = 1'b0; force_empty = 1'b0;
    tick(2);
    wr_ptr = rd_ptr;
    rst_n = 1'b1;
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = DW'(first + i);
      wr_ptr = wr_ptr + 6'd1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: m_valid=%b rd_en=%b busy=%b expected 0 0 0", m_valid, fifo_rd_en, busy);
    end
    vectors++;
    if (m_data !== '0 || rd_count !== '0 || underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: m_data=%0h rd_count=%0d err=%b expected 0 0 0", m_data, rd_count, underflow_err);
    end
  endtask

  task automatic test_streaming();
    int rb, edges;
    do_reset();
    load(1, 8);
    rb = nreads;
    enable = 1'b1; m_ready = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk);
    end while (!m_valid && edges < 10);
    vectors++;
    if (edges !== 3) begin
      miscompares++;
      $display("FAIL stream_latency: got %0d edges expected 3", edges);
    end
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if (m_valid !== 1'b1 || m_data !== DW'(k)) begin
        miscompares++;
        $display("FAIL stream_word%0d: valid=%b data=%0h expected 1 %0h", k, m_valid, m_data, k);
      end
      @(negedge clk);
    end
    tick(3);
    @(negedge clk);
    vectors++;
    if (rd_count !== CW'(8) || nreads - rb !== 8 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_end: rd_count=%0d reads=%0d valid=%b expected 8 8 0", rd_count, nreads - rb, m_valid);
    end
  endtask

  task automatic test_backpressure();
    int rb, lb, bad, cyc;
    do_reset();
    load(1, 5);
    rb = nreads;
    m_ready = 1'b0; enable = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid && m_data !== DW'(1)) bad++;
    end
    vectors++;
    if (nreads - rb !== 2 || m_valid !== 1'b1 || m_data !== DW'(1) || bad !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: reads=%0d valid=%b data=%0h unstable=%0d expected 2 1 1 0", nreads - rb, m_valid, m_data, bad);
    end
    @(posedge clk); #1;
    lb = log_q.size();
    m_ready = 1'b1;
    cyc = 0;
    while (log_q.size() - lb < 5 && cyc < 30) begin @(negedge clk); cyc++; end
    vectors++;
    if (log_q.size() - lb !== 5) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words expected 5", log_q.size() - lb);
    end
    for (int k = 0; k < 5 && lb + k < log_q.size(); k++) begin
      vectors++;
      if (log_q[lb + k] !== DW'(k + 1)) begin
        miscompares++;
        $display("FAIL bp_order%0d: got %0h expected %0h", k, log_q[lb + k], k + 1);
      end
    end
    tick(2);
    vectors++;
    if (rd_count !== CW'(5) || nreads - rb !== 5) begin
      miscompares++;
      $display("FAIL bp_totals: rd_count=%0d reads=%0d expected 5 5", rd_count, nreads - rb);
    end
  endtask

  task automatic test_empty();
    int bad;
    do_reset();
    force_empty = 1'b1; enable = 1'b1; m_ready = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL empty_idle: got %0d active cycles expected 0", bad);
    end
    @(posedge clk); #1 fifo_underflow = 1'b1;
    @(posedge clk); #1 fifo_underflow = 1'b0;
    tick(3);
    @(negedge clk);
    vectors++;
    if (underflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL uf_sticky: got %b expected 1", underflow_err);
    end
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    vectors++;
    if (underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL uf_clear: got %b expected 0", underflow_err);
    end
    @(posedge clk); #1 begin fifo_underflow = 1'b1; clr_err = 1'b1; end
    @(posedge clk); #1 begin fifo_underflow = 1'b0; clr_err = 1'b0; end
    @(negedge clk);
    vectors++;
    if (underflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL uf_set_wins: got %b expected 1", underflow_err);
    end
    enable = 1'b0; force_empty = 1'b0;
  endtask

  task automatic test_stop_mid_read();
    int rb, lb, cyc;
    do_reset();
    load(16'h11, 4);
    rb = nreads; lb = log_q.size();
    m_ready = 1'b1; enable = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!fifo_rd_en && cyc < 10);
    enable = 1'b0;
    tick(8);
    @(negedge clk);
    vectors++;
    if (nreads - rb !== 1 || log_q.size() - lb !== 1) begin
      miscompares++;
      $display("FAIL stop_counts: reads=%0d words=%0d expected 1 1", nreads - rb, log_q.size() - lb);
    end
    vectors++;
    if (log_q.size() > lb && log_q[lb] !== 16'h11) begin
      miscompares++;
      $display("FAIL stop_word: got %0h expected 11", log_q[lb]);
    end
    vectors++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_idle: busy=%b valid=%b expected 0 0", busy, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lb, cyc, rb;
    do_reset();
    load(16'h21, 8);
    lb = log_q.size();
    m_ready = 1'b1; enable = 1'b1; fifo_underflow = 1'b1;
    cyc = 0;
    while (log_q.size() - lb < 2 && cyc < 20) begin @(negedge clk); cyc++; end
    @(posedge clk); #1 begin m_ready = 1'b0; fifo_underflow = 1'b0; end
    tick(5);
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b1 || rd_count === '0 || underflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: valid=%b rd_count=%0d err=%b expected 1 nonzero 1", m_valid, rd_count, underflow_err);
    end
    #2 begin rst_n = 1'b0; enable = 1'b0; end
    #1;
    vectors++;
    if (m_valid !== 1'b0 || m_data !== '0 || fifo_rd_en !== 1'b0 || busy !== 1'b0 ||
        rd_count !== '0 || underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: valid=%b data=%0h rd_en=%b busy=%b cnt=%0d err=%b expected all 0",
               m_valid, m_data, fifo_rd_en, busy, rd_count, underflow_err);
    end
    tick(1);
    rst_n = 1'b1;
    rb = nreads;
    tick(8);
    vectors++;
    if (nreads - rb !== 0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait: reads=%0d valid=%b busy=%b expected 0 0 0", nreads - rb, m_valid, busy);
    end
    enable = 1'b1;
    tick(6);
    vectors++;
    if (nreads - rb === 0) begin
      miscompares++;
      $display("FAIL rst_resume: got %0d reads expected nonzero", nreads - rb);
    end
  endtask

  task automatic test_counter_wrap();
    int lb, cyc;
    do_reset();
    load(16'h100, 17);
    lb = log_q.size();
    m_ready = 1'b1; enable = 1'b1;
    cyc = 0;
    while (log_q.size() - lb < 17 && cyc < 60) begin @(negedge clk); cyc++; end
    tick(3);
    vectors++;
    if (log_q.size() - lb !== 17 || rd_count !== CW'(1)) begin
      miscompares++;
      $display("FAIL wrap: words=%0d rd_count=%0d expected 17 1", log_q.size() - lb, rd_count);
    end
    vectors++;
    if (log_q.size() > 0 && log_q[log_q.size() - 1] !== 16'h110) begin
      miscompares++;
      $display("FAIL wrap_last: got %0h expected 110", log_q[log_q.size() - 1]);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty();
    test_stop_mid_read();
    test_reset_mid();
    test_counter_wrap();
    vectors++;
    if (bad_rd !== 0) begin
      miscompares++;
      $display("FAIL rd_while_empty: got %0d expected 0", bad_rd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of FIFO read data and of downstream data.
REQ-002 Parameter CNT_WIDTH, default 16: width of the transfer counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  1 = fetch words from the FIFO; 0 = stop fetching.
REQ-006 clr_err  input  1  synchronous clear of underflow_err.
REQ-007 fifo_rd_en  output  1  read strobe to the FIFO read port.
REQ-008 fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-009 fifo_empty  input  1  FIFO empty flag.
REQ-010 fifo_underflow  input  1  FIFO underflow flag, one cycle after a read while empty.
REQ-011 m_valid  output  1  downstream word available.
REQ-012 m_data  output  DATA_WIDTH  downstream word.
REQ-013 m_ready  input  1  downstream accepts the word.
REQ-014 rd_count  output  CNT_WIDTH  count of completed downstream transfers.
REQ-015 underflow_err  output  1  sticky FIFO underflow indication.
REQ-016 busy  output  1  1 when state != IDLE or m_valid = 1.

Function
REQ-017 The block SHALL hold a 2-entry in-order output buffer with occupancy occ (0..2) and a 1-bit in-flight flag inf.
REQ-018 The FSM SHALL have states IDLE, RUN and STOP.
- IDLE -> RUN when enable = 1.
- RUN -> STOP when enable = 0.
- STOP -> RUN when enable = 1.
- STOP -> IDLE when enable = 0 and inf = 0.
REQ-019 fifo_rd_en SHALL be 1 only when state = RUN, fifo_empty = 0, and (occ + inf - pop) < 2, where pop = m_valid && m_ready (combinational path from m_ready is permitted).
REQ-020 fifo_rd_en SHALL never be 1 while fifo_empty = 1.
REQ-021 inf SHALL be set in the cycle after fifo_rd_en = 1, and cleared otherwise.
REQ-022 When inf = 1, fifo_data_out SHALL be written to the buffer tail on that edge.
REQ-023 Read latency: a word read at edge N SHALL be visible on m_data at edge N+1 if the buffer was empty.
REQ-024 m_valid SHALL equal (occ != 0); m_data SHALL be the buffer head.
REQ-025 While m_valid = 1 and m_ready = 0, m_data SHALL stay stable.
REQ-026 Simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-027 Buffer overrun (capture when occ = 2 without pop) SHALL be impossible by construction of REQ-019.
REQ-028 rd_count SHALL increment by 1 on every pop and wrap modulo 2^CNT_WIDTH.
REQ-029 underflow_err SHALL set when fifo_underflow = 1 and clear when clr_err = 1; set wins when both occur.
REQ-030 In STOP and IDLE, buffered words SHALL still drain to downstream normally.
REQ-031 Deasserting enable SHALL NOT discard an in-flight word; it SHALL be captured.

Reset
REQ-032 rst_n = 0 SHALL asynchronously force the following, independent of clk:
- state = IDLE, occ = 0, inf = 0
- fifo_rd_en = 0, m_valid = 0, m_data = 0
- rd_count = 0, underflow_err = 0, busy = 0
REQ-033 Reset asserted mid-transfer SHALL drop buffered and in-flight words; after release, the block SHALL wait for enable in IDLE.

Verification
REQ-034 Streaming: FIFO holds 0x0001..0x0008, enable = 1, m_ready = 1.
- m_data shows 0x0001..0x0008 on consecutive cycles after the 2-cycle startup.
- rd_count ends at 8.
REQ-035 Backpressure: m_ready = 0 with 5 words in the FIFO.
- Exactly 2 reads are issued and m_data holds 0x0001 stable.
- After m_ready = 1, order 0x0001..0x0005 is preserved with no loss.
REQ-036 Empty FIFO: enable = 1, fifo_empty = 1 for 20 cycles.
- fifo_rd_en stays 0 and m_valid stays 0.
- Force fifo_underflow = 1 for one cycle: underflow_err = 1 until clr_err pulses.
REQ-037 Stop mid-read: drop enable in the cycle fifo_rd_en = 1.
- The in-flight word is delivered and no further reads occur.
- state reaches IDLE; busy = 0 once m_valid = 0.
REQ-038 Reset: assert rst_n = 0 between clock edges with occ = 2.
- All outputs go to 0 immediately.
- rd_count = 0; no reads occur after release until enable.
REQ-039 Counter wrap: CNT_WIDTH = 4, 17 transfers -> rd_count = 1.
